// File: rtl/fifo_link_arb_pkg.sv
// Shared types and helpers for the serial-link FIFO reader arbiter.
// Master indices are carried in a fixed-width idx_t so the ID queue width is independent of NUM_REQ.
package fifo_link_arb_pkg;

    localparam int unsigned MaxReq = 16;
    localparam int unsigned IdxW   = $clog2(MaxReq);

    typedef logic [IdxW-1:0] idx_t;

    // Round-robin successor of ptr among n masters, wrapping n-1 -> 0.
    function automatic idx_t rr_next(idx_t ptr, int unsigned n);
        if (32'(ptr) + 32'd1 >= n) begin
            return '0;
        end
        return ptr + idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the outstanding-read ID queue.
// Output is registered storage only (no fall-through); a pop on a full queue frees room for a same-cycle push.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [2**AddrW];
    logic [AddrW-1:0]      wr_ptr;
    logic [AddrW-1:0]      rd_ptr;
    logic [CntW-1:0]       cnt;
    logic                  do_push;
    logic                  do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt == FullCnt);
    assign empty_o = (cnt == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/fifo_link_reader_arbiter.sv
// Round-robin OBI arbiter sharing the serial-link receive FIFO reader port among NUM_REQ masters.
// Handshake: a request is accepted when fifo_req_o and fifo_gnt_i are both high; the winner is held until then.
module fifo_link_reader_arbiter
    import fifo_link_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          fifo_req_o,
    output logic                          fifo_we_o,
    output logic [3:0]                    fifo_be_o,
    output logic [ADDR_WIDTH-1:0]         fifo_addr_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_gnt_i,
    input  logic                          fifo_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata_i,
    output logic                          err_o
);

    idx_t rr_ptr;
    idx_t locked_idx;
    idx_t scan_idx;
    idx_t winner;
    idx_t idq_head;
    logic locked;
    logic scan_hit;
    logic lock_req;
    logic winner_req;
    logic hs;
    logic idq_full;
    logic idq_empty;
    logic idq_pop;

    // First requester at or after rr_ptr; rr_ptr+k either equals j or wraps onto it.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!scan_hit && req_i[j] &&
                    ((int'(rr_ptr) + k == j) || (int'(rr_ptr) + k == j + int'(NUM_REQ)))) begin
                    scan_hit = 1'b1;
                    scan_idx = idx_t'(j);
                end
            end
        end
    end

    always_comb begin
        lock_req = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (locked_idx == idx_t'(j)) begin
                lock_req = req_i[j];
            end
        end
    end

    // A locked master that drops its request is not granted on behalf of anyone else.
    assign winner     = locked ? locked_idx : scan_idx;
    assign winner_req = locked ? lock_req : scan_hit;
    assign fifo_req_o = winner_req & ~idq_full;
    assign hs         = fifo_req_o & fifo_gnt_i;
    assign idq_pop    = fifo_rvalid_i & ~idq_empty;
    assign rdata_o    = fifo_rdata_i;

    always_comb begin
        gnt_o        = '0;
        rvalid_o     = '0;
        fifo_we_o    = 1'b0;
        fifo_be_o    = '0;
        fifo_addr_o  = '0;
        fifo_wdata_o = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (fifo_req_o && (winner == idx_t'(j))) begin
                gnt_o[j]     = fifo_gnt_i;
                fifo_we_o    = we_i[j];
                fifo_be_o    = be_i[j*4 +: 4];
                fifo_addr_o  = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                fifo_wdata_o = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
            rvalid_o[j] = idq_pop && (idq_head == idx_t'(j));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            locked     <= 1'b0;
            locked_idx <= '0;
            err_o      <= 1'b0;
        end else begin
            if (fifo_rvalid_i && idq_empty) begin
                err_o <= 1'b1;
            end
            if (locked && !lock_req) begin
                locked <= 1'b0;
            end else if (fifo_req_o) begin
                if (fifo_gnt_i) begin
                    rr_ptr <= rr_next(winner, NUM_REQ);
                    locked <= 1'b0;
                end else begin
                    locked     <= 1'b1;
                    locked_idx <= winner;
                end
            end
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_id_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (idq_full),
        .empty_o    (idq_empty),
        .data_i     (winner),
        .push_i     (hs),
        .data_o     (idq_head),
        .pop_i      (idq_pop)
    );

endmodule

// File: tb/tb_fifo_link_reader_arbiter.sv
// Directed bench for fifo_link_reader_arbiter: grants and responses are checked through expected queues.
module tb_fifo_link_reader_arbiter;

    localparam logic [31:0] ADDR0 = 32'h0000_0100;
    localparam logic [31:0] ADDR1 = 32'h0000_0200;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        fifo_req_o;
    logic        fifo_we_o;
    logic [3:0]  fifo_be_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_wdata_o;
    logic        fifo_gnt_i;
    logic        fifo_rvalid_i;
    logic [31:0] fifo_rdata_i;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  gnt_exp_q[$];
    logic [33:0] rsp_exp_q[$];
    logic [1:0]  mon_g;
    logic [33:0] mon_r;

    fifo_link_reader_arbiter #(
        .NUM_REQ         (2),
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .fifo_req_o    (fifo_req_o),
        .fifo_we_o     (fifo_we_o),
        .fifo_be_o     (fifo_be_o),
        .fifo_addr_o   (fifo_addr_o),
        .fifo_wdata_o  (fifo_wdata_o),
        .fifo_gnt_i    (fifo_gnt_i),
        .fifo_rvalid_i (fifo_rvalid_i),
        .fifo_rdata_i  (fifo_rdata_i),
        .err_o         (err_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(posedge clk_i);
        #1;
        req_i         = req;
        fifo_gnt_i    = gnt;
        fifo_rvalid_i = rv;
        fifo_rdata_i  = rd;
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk_i);
        #1;
        rst_ni        = v;
        req_i         = 2'b00;
        fifo_gnt_i    = 1'b0;
        fifo_rvalid_i = 1'b0;
        fifo_rdata_i  = 32'h0;
    endtask

    task automatic do_reset();
        set_rst(1'b0);
        set_rst(1'b0);
        set_rst(1'b1);
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic expect_gnt(input logic [1:0] g);
        gnt_exp_q.push_back(g);
    endtask

    task automatic expect_rsp(input logic [1:0] v, input logic [31:0] d);
        rsp_exp_q.push_back({v, d});
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (gnt_o != 2'b00) begin
                if (gnt_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %b required none", gnt_o);
                end else begin
                    mon_g = gnt_exp_q.pop_front();
                    check("gnt", 64'(gnt_o), 64'(mon_g));
                end
            end
            if (rvalid_o != 2'b00) begin
                if (rsp_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %b/%h required none", rvalid_o, rdata_o);
                end else begin
                    mon_r = rsp_exp_q.pop_front();
                    check("rsp", 64'({rvalid_o, rdata_o}), 64'(mon_r));
                end
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        req_i         = 2'b00;
        we_i          = 2'b10;
        be_i          = {4'h3, 4'hF};
        addr_i        = {ADDR1, ADDR0};
        wdata_i       = {32'h1111_2222, 32'h3333_4444};
        fifo_gnt_i    = 1'b0;
        fifo_rvalid_i = 1'b0;
        fifo_rdata_i  = 32'h0;

        // reset state
        sample();
        check("rst_gnt", 64'(gnt_o), 64'h0);
        check("rst_rvalid", 64'(rvalid_o), 64'h0);
        check("rst_fifo_req", 64'(fifo_req_o), 64'h0);
        check("rst_err", 64'(err_o), 64'h0);
        set_rst(1'b1);

        // single master, one-cycle FIFO latency
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        sample();
        check("t1_fifo_req", 64'(fifo_req_o), 64'h1);
        check("t1_addr", 64'(fifo_addr_o), 64'(ADDR0));
        check("t1_be", 64'(fifo_be_o), 64'hF);
        drive(2'b00, 1'b1, 1'b1, 32'hCAFE_0001);
        expect_rsp(2'b01, 32'hCAFE_0001);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // fairness with both masters requesting
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1, (i > 0), 32'hA000_0000 + 32'(i - 1));
            expect_gnt((i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) expect_rsp((i % 2 == 1) ? 2'b01 : 2'b10, 32'hA000_0000 + 32'(i - 1));
        end
        drive(2'b00, 1'b0, 1'b1, 32'hA000_0003);
        expect_rsp(2'b10, 32'hA000_0003);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // FIFO empty: master 0 locked while rr_ptr points at master 1
        do_reset();
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        drive(2'b00, 1'b0, 1'b1, 32'hB000_0000);
        expect_rsp(2'b01, 32'hB000_0000);
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        sample();
        check("t3_locked_gnt", 64'(gnt_o), 64'h0);
        check("t3_locked_req", 64'(fifo_req_o), 64'h1);
        check("t3_locked_addr", 64'(fifo_addr_o), 64'(ADDR0));
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        drive(2'b11, 1'b1, 1'b1, 32'hB000_0001);
        expect_gnt(2'b10);
        expect_rsp(2'b01, 32'hB000_0001);
        drive(2'b00, 1'b0, 1'b1, 32'hB000_0002);
        expect_rsp(2'b10, 32'hB000_0002);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // ID queue full blocks requests until a response pops
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b10);
        sample();
        check("t4_we", 64'(fifo_we_o), 64'h1);
        check("t4_be", 64'(fifo_be_o), 64'h3);
        check("t4_wdata", 64'(fifo_wdata_o), 64'h1111_2222);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        sample();
        check("t4_full_req", 64'(fifo_req_o), 64'h0);
        check("t4_full_gnt", 64'(gnt_o), 64'h0);
        drive(2'b11, 1'b1, 1'b1, 32'hC000_0000);
        expect_rsp(2'b01, 32'hC000_0000);
        sample();
        check("t4_pop_req", 64'(fifo_req_o), 64'h0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        sample();
        check("t4_resume_req", 64'(fifo_req_o), 64'h1);
        drive(2'b00, 1'b0, 1'b1, 32'hC000_0001);
        expect_rsp(2'b10, 32'hC000_0001);
        drive(2'b00, 1'b0, 1'b1, 32'hC000_0002);
        expect_rsp(2'b01, 32'hC000_0002);
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // spurious response with nothing outstanding
        do_reset();
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_0000);
        sample();
        check("t5_rvalid", 64'(rvalid_o), 64'h0);
        check("t5_err_before", 64'(err_o), 64'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        sample();
        check("t5_err_set", 64'(err_o), 64'h1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        sample();
        check("t5_err_sticky", 64'(err_o), 64'h1);
        do_reset();
        sample();
        check("t5_err_cleared", 64'(err_o), 64'h0);

        // reset with one read in flight
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b10);
        set_rst(1'b0);
        sample();
        check("t6_rst_gnt", 64'(gnt_o), 64'h0);
        check("t6_rst_rvalid", 64'(rvalid_o), 64'h0);
        check("t6_rst_req", 64'(fifo_req_o), 64'h0);
        set_rst(1'b1);
        fifo_rvalid_i = 1'b1;
        fifo_rdata_i  = 32'hBAD0_0000;
        sample();
        check("t6_stale_rvalid", 64'(rvalid_o), 64'h0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt(2'b01);
        sample();
        check("t6_err", 64'(err_o), 64'h1);
        drive(2'b00, 1'b0, 1'b1, 32'hF000_0001);
        expect_rsp(2'b01, 32'hF000_0001);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        sample();

        // final report
        check("gnt_q_drained", 64'(gnt_exp_q.size()), 64'h0);
        check("rsp_q_drained", 64'(rsp_exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
